ball_move_ctrl: RTL and testbench

BALL_MOVE_CTRL -- requirements
Module: ball_move_ctrl

---
 rtl/maze_pkg.sv | 33 +++
 rtl/axis_step.sv | 26 ++
 rtl/ball_move_ctrl.sv | 156 +++++++++++++++
 tb/tb_ball_move_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and screen limits for the maze ball logic: state encoding,
// direction command layout, default ball size and coordinate bounds.
package maze_pkg;

  localparam int COORD_W      = 11;
  localparam int BALL_W_DEF   = 8;
  localparam int SCREEN_X_MAX = 632;
  localparam int SCREEN_Y_MAX = 472;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_FRAME,
    SETTLE,
    APPLY,
    WIN
  } ball_state_e;

  typedef struct packed {
    logic right;
    logic left;
    logic up;
    logic down;
  } dir_cmd_t;

  // Goal region runs from (gx,gy) to the screen limits, which the position never exceeds.
  function automatic logic in_goal(input logic [COORD_W-1:0] x,
                                   input logic [COORD_W-1:0] y,
                                   input logic [COORD_W-1:0] gx,
                                   input logic [COORD_W-1:0] gy);
    return (x >= gx) && (y >= gy);
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis single-pixel step decision with bounds and wall checks; never wraps.
module axis_step
  import maze_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic [W-1:0] pos,
  input  logic         inc,
  input  logic         dec,
  input  logic         stop_inc,
  input  logic         stop_dec,
  input  logic [W-1:0] max,
  output logic [W-1:0] next_pos
);

  always_comb begin
    next_pos = pos;
    // Opposing requests cancel on this axis.
    if (inc && !dec && !stop_inc && (pos < max)) begin
      next_pos = pos + W'(1);
    end else if (dec && !inc && !stop_dec && (pos != '0)) begin
      next_pos = pos - W'(1);
    end
  end

endmodule

// File: rtl/ball_move_ctrl.sv
// Frame-paced ball mover: each frame applies `speed` single-pixel steps, two cycles each.
// Define DIAG_MOVE_EN to let both axes step together; otherwise x has priority over y.
module ball_move_ctrl
  import maze_pkg::*;
#(
  parameter int START_X = 70,
  parameter int START_Y = 35,
  parameter int BALL_W  = BALL_W_DEF,
  parameter int X_MAX   = SCREEN_X_MAX,
  parameter int Y_MAX   = SCREEN_Y_MAX,
  parameter int GOAL_X  = 600,
  parameter int GOAL_Y  = 200
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               dir_valid,
  input  logic               dir_right,
  input  logic               dir_left,
  input  logic               dir_up,
  input  logic               dir_down,
  input  logic [2:0]         speed,
  input  logic               stop_right,
  input  logic               stop_left,
  input  logic               stop_up,
  input  logic               stop_down,
  input  logic               restart,
  output logic [COORD_W-1:0] x_ball,
  output logic [COORD_W-1:0] y_ball,
  output logic [4:0]         ball_width,
  output logic               moving,
  output logic               goal_reached
);

  ball_state_e        state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  dir_cmd_t           cmd_q, cmd_d;
  logic [2:0]         step_cnt_q, step_cnt_d;
  logic               moving_q, moving_d;
  logic               goal_q, goal_d;

  // Axis 0 is x, axis 1 is y.
  logic [1:0][COORD_W-1:0] pos_v, max_v, next_v;
  logic [1:0]              inc_v, dec_v, stop_inc_v, stop_dec_v;
  logic [COORD_W-1:0]      x_next, y_next, y_apply;

  assign pos_v      = {y_q, x_q};
  assign max_v      = {COORD_W'(Y_MAX), COORD_W'(X_MAX)};
  assign inc_v      = {cmd_q.down, cmd_q.right};
  assign dec_v      = {cmd_q.up, cmd_q.left};
  assign stop_inc_v = {stop_down, stop_right};
  assign stop_dec_v = {stop_up, stop_left};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      axis_step #(.W(COORD_W)) u_step (
        .pos      (pos_v[gi]),
        .inc      (inc_v[gi]),
        .dec      (dec_v[gi]),
        .stop_inc (stop_inc_v[gi]),
        .stop_dec (stop_dec_v[gi]),
        .max      (max_v[gi]),
        .next_pos (next_v[gi])
      );
    end
  endgenerate

  assign x_next = next_v[0];
  assign y_next = next_v[1];

  always_comb begin
`ifdef DIAG_MOVE_EN
    y_apply = y_next;
`else
    y_apply = (x_next != x_q) ? y_q : y_next;
`endif
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    cmd_d      = cmd_q;
    step_cnt_d = step_cnt_q;
    goal_d     = goal_q;

    if (dir_valid) begin
      cmd_d = '{right: dir_right, left: dir_left, up: dir_up, down: dir_down};
    end

    case (state_q)
      IDLE: state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (frame_tick && (speed != 3'd0) && (cmd_q != '0)) begin
          state_d    = SETTLE;
          step_cnt_d = speed;
        end
      end
      // SETTLE gives the collision block a cycle to see the latest position.
      SETTLE: state_d = APPLY;
      APPLY: begin
        x_d        = x_next;
        y_d        = y_apply;
        step_cnt_d = step_cnt_q - 3'd1;
        if (in_goal(x_next, y_apply, COORD_W'(GOAL_X), COORD_W'(GOAL_Y))) begin
          goal_d  = 1'b1;
          state_d = WIN;
        end else if (step_cnt_q == 3'd1) begin
          state_d = WAIT_FRAME;
        end else begin
          state_d = SETTLE;
        end
      end
      WIN:     state_d = WIN;
      default: state_d = IDLE;
    endcase

    if (restart) begin
      x_d        = COORD_W'(START_X);
      y_d        = COORD_W'(START_Y);
      goal_d     = 1'b0;
      step_cnt_d = 3'd0;
      state_d    = WAIT_FRAME;
    end

    moving_d = (state_d == SETTLE) || (state_d == APPLY);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= COORD_W'(START_X);
      y_q        <= COORD_W'(START_Y);
      cmd_q      <= '0;
      step_cnt_q <= 3'd0;
      moving_q   <= 1'b0;
      goal_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      cmd_q      <= cmd_d;
      step_cnt_q <= step_cnt_d;
      moving_q   <= moving_d;
      goal_q     <= goal_d;
    end
  end

  assign x_ball       = x_q;
  assign y_ball       = y_q;
  assign ball_width   = 5'(BALL_W);
  assign moving       = moving_q;
  assign goal_reached = goal_q;

endmodule

// File: tb/tb_ball_move_ctrl.sv
// Scoreboard bench for ball_move_ctrl: a frame-level model predicts position, goal
// flag and motion length; a monitor compares each completed frame of motion.
module tb_ball_move_ctrl;

  localparam int SX = 70;
  localparam int SY = 35;
  localparam int XM = 632;
  localparam int YM = 472;
  localparam int GX = 600;
  localparam int GY = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_tick;
  logic        dir_valid;
  logic        dir_right, dir_left, dir_up, dir_down;
  logic [2:0]  speed;
  logic        stop_right, stop_left, stop_up, stop_down;
  logic        restart;
  logic [10:0] x_ball, y_ball;
  logic [4:0]  ball_width;
  logic        moving;
  logic        goal_reached;

  always #5 clk = ~clk;

  ball_move_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .dir_valid    (dir_valid),
    .dir_right    (dir_right),
    .dir_left     (dir_left),
    .dir_up       (dir_up),
    .dir_down     (dir_down),
    .speed        (speed),
    .stop_right   (stop_right),
    .stop_left    (stop_left),
    .stop_up      (stop_up),
    .stop_down    (stop_down),
    .restart      (restart),
    .x_ball       (x_ball),
    .y_ball       (y_ball),
    .ball_width   (ball_width),
    .moving       (moving),
    .goal_reached (goal_reached)
  );

  // Maze walls emulated from the live ball position.
  bit wr_en, wl_en, wu_en, wd_en;
  int wall_r, wall_l, wall_u, wall_d;
  assign stop_right = wr_en && (int'(x_ball) >= wall_r);
  assign stop_left  = wl_en && (int'(x_ball) <= wall_l);
  assign stop_down  = wd_en && (int'(y_ball) >= wall_d);
  assign stop_up    = wu_en && (int'(y_ball) <= wall_u);

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int x;
    int y;
    int goal;
    int cyc;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state.
  int mx, my;
  bit mgoal;
  bit cr, cl, cu, cd;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_frame(input int spd, output int cyc);
    int dx, dy;
    cyc = 0;
    if (mgoal || spd == 0 || !(cr || cl || cu || cd)) return;
    for (int i = 0; i < spd; i++) begin
      dx = 0;
      dy = 0;
      if (cr && !cl && !(wr_en && mx >= wall_r) && mx < XM) dx = 1;
      else if (cl && !cr && !(wl_en && mx <= wall_l) && mx > 0) dx = -1;
      if (cd && !cu && !(wd_en && my >= wall_d) && my < YM) dy = 1;
      else if (cu && !cd && !(wu_en && my <= wall_u) && my > 0) dy = -1;
`ifndef DIAG_MOVE_EN
      if (dx != 0) dy = 0;
`endif
      mx += dx;
      my += dy;
      cyc += 2;
      if (mx >= GX && my >= GY) begin
        mgoal = 1'b1;
        break;
      end
    end
  endtask

  // Monitor: a run of moving cycles ends one frame transaction.
  int   mon_cnt = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (moving) begin
      mon_cnt++;
    end else if (mon_cnt > 0) begin
      if (sb_q.size() == 0) begin
        check("frame_expected", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        $display("frame: x=%0d y=%0d goal=%0d moving_cycles=%0d (exp %0d,%0d,%0d,%0d)",
                 x_ball, y_ball, goal_reached, mon_cnt, mon_e.x, mon_e.y, mon_e.goal, mon_e.cyc);
        check("frame_x", int'(x_ball), mon_e.x);
        check("frame_y", int'(y_ball), mon_e.y);
        check("frame_goal", int'(goal_reached), mon_e.goal);
        check("frame_moving_cycles", mon_cnt, mon_e.cyc);
      end
      mon_cnt = 0;
    end
  end

  task automatic set_dir(input bit r, input bit l, input bit u, input bit d);
    dir_valid = 1'b1;
    dir_right = r;
    dir_left  = l;
    dir_up    = u;
    dir_down  = d;
    @(posedge clk); #1;
    dir_valid = 1'b0;
    {dir_right, dir_left, dir_up, dir_down} = 4'($urandom);
    {cr, cl, cu, cd} = {r, l, u, d};
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
    mx = SX;
    my = SY;
    mgoal = 1'b0;
    $display("restart: x=%0d y=%0d goal=%0d", x_ball, y_ball, goal_reached);
    check("restart_x", int'(x_ball), SX);
    check("restart_y", int'(y_ball), SY);
    check("restart_goal", int'(goal_reached), 0);
    check("restart_moving", int'(moving), 0);
  endtask

  // One frame tick; abort_k>0 cuts the frame after abort_k moving cycles.
  task automatic do_frame(input int spd, input bit extra, input int abort_k, input bit abort_rst);
    int cyc;
    int budget;
    speed = 3'(spd);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    model_frame(spd, cyc);
    if (cyc > abort_k && abort_k > 0) begin
      sb_q.push_back('{x: SX, y: SY, goal: 0, cyc: abort_k});
      mx = SX;
      my = SY;
      mgoal = 1'b0;
      repeat (abort_k - 1) @(posedge clk);
      #1;
      if (abort_rst) begin
        rst_n = 1'b0;
        {cr, cl, cu, cd} = 4'b0;
      end else begin
        restart = 1'b1;
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      restart = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end else if (cyc > 0) begin
      sb_q.push_back('{x: mx, y: my, goal: int'(mgoal), cyc: cyc});
      if (extra && cyc >= 4) begin
        @(posedge clk); #1;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
      end
    end
    budget = 0;
    while (sb_q.size() != 0 && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    check("frame_drain", sb_q.size(), 0);
    sb_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("post_x", int'(x_ball), mx);
    check("post_y", int'(y_ball), my);
    check("post_goal", int'(goal_reached), int'(mgoal));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    frame_tick = 1'b0;
    dir_valid = 1'b0;
    {dir_right, dir_left, dir_up, dir_down} = 4'b0;
    speed = 3'd0;
    restart = 1'b0;
    {wr_en, wl_en, wu_en, wd_en} = 4'b0;
    wall_r = 0; wall_l = 0; wall_u = 0; wall_d = 0;
    mx = SX; my = SY; mgoal = 1'b0;
    {cr, cl, cu, cd} = 4'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_x", int'(x_ball), SX);
    check("reset_y", int'(y_ball), SY);
    check("reset_moving", int'(moving), 0);
    check("reset_goal", int'(goal_reached), 0);
    check("ball_width", int'(ball_width), 8);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Right at speed 3, with a stray tick mid-frame that must be ignored.
    set_dir(1, 0, 0, 0);
    do_frame(3, 1, 0, 0);
    check("req023_x", int'(x_ball), 73);

    // Wall appears after the first step.
    do_restart();
    wr_en = 1'b1; wall_r = SX + 1;
    do_frame(4, 0, 0, 0);
    wr_en = 1'b0;
    check("req024_x", int'(x_ball), 71);

    // Opposing requests cancel.
    do_restart();
    set_dir(1, 1, 0, 0);
    do_frame(2, 0, 0, 0);
    check("req025_x", int'(x_ball), SX);

    // Diagonal request.
    do_restart();
    set_dir(1, 0, 0, 1);
    do_frame(1, 0, 0, 0);
`ifdef DIAG_MOVE_EN
    check("req027_y", int'(y_ball), 36);
`else
    check("req027_y", int'(y_ball), 35);
`endif

    // Right edge clamp.
    do_restart();
    set_dir(1, 0, 0, 0);
    for (int i = 0; i < 80; i++) do_frame(7, 0, 0, 0);
    do_frame(2, 0, 0, 0);
    do_frame(1, 0, 0, 0);
    check("req026_x", int'(x_ball), XM);

    // Walk into the goal corner, confirm WIN freezes, then restart.
    do_restart();
    set_dir(1, 0, 0, 0);
    for (int i = 0; i < 75; i++) do_frame(7, 0, 0, 0);
    do_frame(5, 0, 0, 0);
    set_dir(0, 0, 0, 1);
    for (int i = 0; i < 23; i++) do_frame(7, 0, 0, 0);
    do_frame(4, 0, 0, 0);
    check("req028_goal", int'(goal_reached), 1);
    set_dir(0, 1, 1, 0);
    do_frame(3, 0, 0, 0);
    check("win_frozen_x", int'(x_ball), GX);
    check("win_frozen_y", int'(y_ball), GY);
    do_restart();

    // Aborted frames: restart, then reset (which also clears the command).
    set_dir(1, 0, 0, 0);
    do_frame(5, 0, 3, 0);
    do_frame(5, 0, 4, 1);
    do_frame(3, 0, 0, 0);

    // Randomized traffic.
    set_dir(1, 0, 0, 1);
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 5) begin
        wr_en = ($urandom_range(0, 3) == 0); wall_r = mx + $urandom_range(0, 4);
        wl_en = ($urandom_range(0, 3) == 0); wall_l = mx - $urandom_range(0, 4);
        wd_en = ($urandom_range(0, 3) == 0); wall_d = my + $urandom_range(0, 4);
        wu_en = ($urandom_range(0, 3) == 0); wall_u = my - $urandom_range(0, 4);
        do_frame($urandom_range(0, 7), 1'($urandom_range(0, 1)), 0, 0);
        {wr_en, wl_en, wu_en, wd_en} = 4'b0;
      end else if (op <= 7) begin
        set_dir(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      end else if (op == 8) begin
        {dir_right, dir_left, dir_up, dir_down} = 4'($urandom);
        @(posedge clk); #1;
      end else begin
        do_restart();
      end
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
